ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_sync_edge.sv | 36 +++
 rtl/ps2_host_tx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the keyboard tracker.
//   - host transmitter state encoding
//   - default inhibit / timeout durations in system-clock cycles (50 MHz)
//   - width of the cycle counter that measures both durations
//   - odd-parity helper for a PS/2 data byte
package ps2_pkg;

    localparam int PS2_INHIBIT_CYCLES = 5000;    // 100 us clock-low inhibit
    localparam int PS2_TIMEOUT_CYCLES = 750000;  // 15 ms wait for any device edge
    localparam int PS2_CNT_W          = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_XFER    = 3'd3,
        ST_ACK     = 3'd4,
        ST_WAIT_HI = 3'd5
    } ps2_tx_state_t;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 pad level, plus falling-edge detect.
//   clock   : system clock
//   resetn  : asynchronous active-low reset; all flops preset to 1 (idle bus level)
//   din     : raw pad level
//   level   : synchronized level
//   fall    : one-cycle pulse when level was 1 last cycle and is 0 now
module ps2_sync_edge (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Presetting to 1 keeps a released bus from looking like a fall after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so each flop takes the previous stage's old value.
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibits the bus, requests to send, then shifts out start, 8 data bits
// (LSB first), odd parity and stop on device clock falls, and checks the
// device ack bit. The pads are open-drain: an *_oe of 1 pulls that pad low
// in the top-level wrapper; this block has no inout ports.
//   clock, resetn            : system clock, asynchronous active-low reset
//   cmd_data/cmd_valid/ready : byte handshake, accepted only in IDLE
//   ps2_clk_in, ps2_dat_in   : raw pad levels
//   ps2_clk_oe, ps2_dat_oe   : pull-low enables for the pads
//   done / err               : one-cycle result pulses (ack / nack or timeout)
//   busy                     : high whenever not IDLE
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam logic [PS2_CNT_W-1:0] INHIBIT_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] TIMEOUT_LAST = PS2_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] CNT_ONE      = PS2_CNT_W'(1);

    logic clk_level;
    logic clk_fall;
    logic dat_level;
    logic dat_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (ps2_clk_in),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (ps2_dat_in),
        .level  (dat_level),
        .fall   (dat_fall_unused)
    );

    ps2_tx_state_t         state_q, state_d;
    logic [8:0]            shift_q, shift_d;     // {parity, data}, shifted right per bit
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [PS2_CNT_W-1:0]  cyc_q, cyc_d;
    logic                  dat_oe_q, dat_oe_d;
    logic                  nack_q, nack_d;       // ack bit sampled high
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  device_timed;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cyc_q     <= '0;
            dat_oe_q  <= 1'b0;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_q     <= cyc_d;
            dat_oe_q  <= dat_oe_d;
            nack_q    <= nack_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // States in which progress depends on the device clocking the bus.
    assign device_timed = (state_q == ST_REQ) || (state_q == ST_XFER) ||
                          (state_q == ST_ACK) || (state_q == ST_WAIT_HI);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        cyc_d     = cyc_q;
        dat_oe_d  = dat_oe_q;
        nack_d    = nack_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d   = ST_INHIBIT;
                    shift_d   = {odd_parity(cmd_data), cmd_data};
                    bit_cnt_d = '0;
                    cyc_d     = '0;
                    dat_oe_d  = 1'b0;
                    nack_d    = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (cyc_q == INHIBIT_LAST) begin
                    // Start bit goes low on the same edge the clock line is released.
                    state_d  = ST_REQ;
                    dat_oe_d = 1'b1;
                    cyc_d    = '0;
                end else begin
                    cyc_d = cyc_q + CNT_ONE;
                end
            end
            ST_REQ: begin
                if (clk_fall) begin
                    dat_oe_d  = ~shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 4'd1;
                    state_d   = ST_XFER;
                end
            end
            ST_XFER: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        dat_oe_d = 1'b0;            // stop bit: release data
                        state_d  = ST_ACK;
                    end else begin
                        dat_oe_d = ~shift_q[0];     // data bits 1..7, then parity
                        shift_d  = shift_q >> 1;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    nack_d  = dat_level;
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (clk_level && dat_level) begin
                    done_d  = ~nack_q;
                    err_d   = nack_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The watchdog restarts on every device clock fall; expiry overrides
        // whatever the state logic chose, so done and err can never coincide.
        if (device_timed) begin
            if (clk_fall) begin
                cyc_d = '0;
            end else if (cyc_q == TIMEOUT_LAST) begin
                state_d  = ST_IDLE;
                dat_oe_d = 1'b0;
                done_d   = 1'b0;
                err_d    = 1'b1;
                cyc_d    = '0;
            end else begin
                cyc_d = cyc_q + CNT_ONE;
            end
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign ps2_clk_oe = (state_q == ST_INHIBIT);
    assign ps2_dat_oe = dat_oe_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple device model.
module tb_ps2_host_tx;

    localparam int INHIBIT = 5000;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 30;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, done, err, busy;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line, dat_line;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    // Wired-AND bus with pull-ups.
    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    always #10 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
    end

    // Present a byte for one cycle, then measure how long the clock line is inhibited.
    task automatic issue(input logic [7:0] b, output int inh_len);
        @(negedge clock);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        inh_len   = 0;
        while (ps2_clk_oe === 1'b1 && inh_len < 3 * INHIBIT) begin
            inh_len++;
            @(negedge clock);
        end
    endtask

    // Full device side of a frame: 10 clock pulses sampling the data line late in
    // each low phase, then the ack pulse. spoil drives a competing request mid-frame.
    task automatic run_xfer(input logic [7:0] b, input bit ack_low, input bit spoil,
                            output logic [10:0] bits, output int inh_len);
        issue(b, inh_len);
        repeat (10) @(negedge clock);
        bits    = '0;
        bits[0] = dat_line;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            bits[k] = dat_line;
            if (spoil && k == 3) begin
                cmd_data  = 8'h55;
                cmd_valid = 1'b1;
            end
            if (spoil && k == 10) begin
                cmd_valid = 1'b0;
                cmd_data  = 8'h00;
            end
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clock);
        end
        if (ack_low) dev_dat_low = 1'b1;
        repeat (5) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clock);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clock);
        dev_dat_low = 1'b0;
        repeat (20) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total++;
        if ({ps2_clk_oe, ps2_dat_oe, done, err, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 00000", {ps2_clk_oe, ps2_dat_oe, done, err, busy});
        end
        resetn = 1'b1;
        @(negedge clock);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_send(input string name, input logic [7:0] b, input bit ack_low,
                             input bit spoil, input logic [10:0] exp_bits);
        logic [10:0] bits;
        int          inh;
        int          d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        run_xfer(b, ack_low, spoil, bits, inh);
        total++;
        if (inh !== INHIBIT) begin
            bad++;
            $display("FAIL %s inhibit_len: got %0d want %0d", name, inh, INHIBIT);
        end
        total++;
        if (bits !== exp_bits) begin
            bad++;
            $display("FAIL %s frame_bits: got %b want %b", name, bits, exp_bits);
        end
        total++;
        if (done_cnt - d0 !== (ack_low ? 1 : 0)) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d want %0d", name, done_cnt - d0, ack_low ? 1 : 0);
        end
        total++;
        if (err_cnt - e0 !== (ack_low ? 0 : 1)) begin
            bad++;
            $display("FAIL %s err_pulses: got %0d want %0d", name, err_cnt - e0, ack_low ? 0 : 1);
        end
        total++;
        if ({cmd_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
            bad++;
            $display("FAIL %s idle_after: got %b want 1000", name, {cmd_ready, busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_timeout();
        int inh;
        int n;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        issue(8'hAA, inh);
        n = 0;
        while (err !== 1'b1 && n < 3 * TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n !== TIMEOUT) begin
            bad++;
            $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT);
        end
        total++;
        if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_release: got %b want 00", {ps2_clk_oe, ps2_dat_oe});
        end
        @(negedge clock);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_ready: got %b want 1", cmd_ready);
        end
        repeat (3) @(negedge clock);
        total++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL timeout_pulses: got err=%0d done=%0d want err=1 done=0", err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int inh;
        issue(8'h00, inh);
        repeat (10) @(negedge clock);
        for (int k = 1; k <= 4; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            if (k < 4) begin
                dev_clk_low = 1'b0;
                repeat (HALF) @(negedge clock);
            end
        end
        total++;
        if ({busy, ps2_dat_oe} !== 2'b11) begin
            bad++;
            $display("FAIL midreset_before: got busy,dat_oe=%b want 11", {busy, ps2_dat_oe});
        end
        #3 resetn = 1'b0;
        #1;
        total++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, err} !== 5'b0) begin
            bad++;
            $display("FAIL midreset_async: got %b want 00000", {ps2_clk_oe, ps2_dat_oe, busy, done, err});
        end
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        test_send("after_reset_ff", 8'hFF, 1'b1, 1'b0, {1'b1, 1'b1, 8'hFF, 1'b0});
    endtask

    initial begin
        test_reset();
        test_send("send_ed", 8'hED, 1'b1, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0});
        test_send("send_07", 8'h07, 1'b1, 1'b0, {1'b1, 1'b0, 8'h07, 1'b0});
        test_send("nack_f4", 8'hF4, 1'b0, 1'b0, {1'b1, 1'b0, 8'hF4, 1'b0});
        test_timeout();
        test_reset_mid();
        test_send("ignore_3c", 8'h3C, 1'b1, 1'b1, {1'b1, 1'b1, 8'h3C, 1'b0});
        repeat (5) @(negedge clock);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_no_queue: got busy=%b want 0", busy);
        end
        total++;
        if (both_cnt !== 0) begin
            bad++;
            $display("FAIL done_err_overlap: got %0d want 0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
